// File: rtl/ifu_core_if.sv
`default_nettype none
// ============================================================================
// Module      : ifu_core_if
// Description : Handshake/bus bundle between the IFU PC generator and the
//               downstream fetch/decode stage plus the execute redirect path.
//               master = PC generator side, slave = consumer/driver side.
//   i_ready         downstream accepts o_pc this cycle
//   o_valid         o_pc holds a valid fetch address
//   i_jmp_en        redirect request
//   i_jmp_pc        redirect target
//   o_pc            current fetch PC (registered)
//   o_pc_next       PC loaded on the next advance (combinational)
//   o_jmp_misalign  only with IFU_JMP_ALIGN_EN: accepted target was misaligned
// Configuration macro: IFU_JMP_ALIGN_EN
// Revision    : 1.0 - initial release
// ============================================================================
interface ifu_core_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  i_ready;
   logic                  o_valid;
   logic                  i_jmp_en;
   logic [ADDR_WIDTH-1:0] i_jmp_pc;
   logic [ADDR_WIDTH-1:0] o_pc;
   logic [ADDR_WIDTH-1:0] o_pc_next;
`ifdef IFU_JMP_ALIGN_EN
   logic                  o_jmp_misalign;
`endif

   modport master (
      input  i_ready,
      input  i_jmp_en,
      input  i_jmp_pc,
      output o_valid,
      output o_pc,
`ifdef IFU_JMP_ALIGN_EN
      output o_jmp_misalign,
`endif
      output o_pc_next
   );

   modport slave (
      output i_ready,
      output i_jmp_en,
      output i_jmp_pc,
      input  o_valid,
      input  o_pc,
`ifdef IFU_JMP_ALIGN_EN
      input  o_jmp_misalign,
`endif
      input  o_pc_next
   );
endinterface
`default_nettype wire

// File: rtl/ifu_core.sv
`default_nettype none
// ============================================================================
// Module      : ifu_core
// Description : Instruction fetch PC generator. Holds the fetch PC, selects
//               the next PC (live redirect > pending redirect > pc+PC_STEP)
//               and advances on o_valid && i_ready. Redirects arriving while
//               stalled are latched so they are never lost.
// Ports       : i_clk  - clock, rising edge
//               i_rst  - synchronous active-high reset
//               bus    - ifu_core_if.master (ready/valid, redirect, PCs)
// Configuration macro: IFU_JMP_ALIGN_EN - force target low bits to zero and
//               report misaligned accepted targets on o_jmp_misalign.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_core #(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
   parameter int                    PC_STEP    = 4
) (
   input  wire logic   i_clk,
   input  wire logic   i_rst,
   ifu_core_if.master  bus
);

   localparam logic [ADDR_WIDTH-1:0] c_pc_step = ADDR_WIDTH'(PC_STEP);

   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                  valid_q, valid_d;
   logic                  pend_q, pend_d;
   logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;

   logic [ADDR_WIDTH-1:0] w_live_tgt;
   logic [ADDR_WIDTH-1:0] w_pend_tgt;
   logic [ADDR_WIDTH-1:0] w_sel_pc;
   logic                  w_advance;

`ifdef IFU_JMP_ALIGN_EN
   // PC_STEP is assumed to be a power of two; the mask clears its low bits.
   localparam logic [ADDR_WIDTH-1:0] c_align_mask = ~(c_pc_step - 1'b1);
   logic                  jmp_misalign_q, jmp_misalign_d;
   logic                  w_sel_misaligned;

   assign w_live_tgt = bus.i_jmp_pc & c_align_mask;
   // Pending target is kept raw so its misalignment can still be reported
   // at the moment it is finally accepted.
   assign w_pend_tgt = pend_pc_q & c_align_mask;
`else
   assign w_live_tgt = bus.i_jmp_pc;
   assign w_pend_tgt = pend_pc_q;
`endif

   always_comb begin
      w_sel_pc  = pc_q + c_pc_step;
      if (bus.i_jmp_en) begin
         w_sel_pc = w_live_tgt;
      end else if (pend_q) begin
         w_sel_pc = w_pend_tgt;
      end

      w_advance = valid_q && bus.i_ready;

      pc_d      = pc_q;
      valid_d   = 1'b1;
      pend_d    = pend_q;
      pend_pc_d = pend_pc_q;

      if (w_advance) begin
         pc_d   = w_sel_pc;
         pend_d = 1'b0;
      end else if (valid_q && bus.i_jmp_en) begin
         // Stalled redirect: latest one wins. Before the first valid cycle
         // the request is dropped, since nothing is being fetched yet.
         pend_d    = 1'b1;
         pend_pc_d = bus.i_jmp_pc;
      end
   end

`ifdef IFU_JMP_ALIGN_EN
   always_comb begin
      w_sel_misaligned = 1'b0;
      if (bus.i_jmp_en) begin
         w_sel_misaligned = |(bus.i_jmp_pc & ~c_align_mask);
      end else if (pend_q) begin
         w_sel_misaligned = |(pend_pc_q & ~c_align_mask);
      end
      jmp_misalign_d = w_advance && w_sel_misaligned;
   end
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pc_q      <= RESET_PC;
         valid_q   <= 1'b0;
         pend_q    <= 1'b0;
         pend_pc_q <= '0;
`ifdef IFU_JMP_ALIGN_EN
         jmp_misalign_q <= 1'b0;
`endif
      end else begin
         pc_q      <= pc_d;
         valid_q   <= valid_d;
         pend_q    <= pend_d;
         pend_pc_q <= pend_pc_d;
`ifdef IFU_JMP_ALIGN_EN
         jmp_misalign_q <= jmp_misalign_d;
`endif
      end
   end

   assign bus.o_pc      = pc_q;
   assign bus.o_valid   = valid_q;
   assign bus.o_pc_next = w_sel_pc;
`ifdef IFU_JMP_ALIGN_EN
   assign bus.o_jmp_misalign = jmp_misalign_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifu_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_core
// Description : Self-checking bench for ifu_core. Directed scenarios followed
//               by a randomized run, all compared against a transaction-level
//               model of the fetch address stream.
// Configuration macro: IFU_JMP_ALIGN_EN (model follows the DUT build)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_core;

   localparam logic [31:0] c_reset_pc = 32'h8000_0000;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   ifu_core_if #(.ADDR_WIDTH(32)) bus ();

   ifu_core #(
      .ADDR_WIDTH (32),
      .RESET_PC   (c_reset_pc),
      .PC_STEP    (4)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: current fetch address, whether fetching has started,
   // and a queue holding at most one redirect remembered across a stall.
   logic [31:0] m_pc;
   logic        m_valid;
   logic [31:0] m_pend[$];
   logic        m_mis;

   function automatic logic [31:0] tgt(input logic [31:0] a);
`ifdef IFU_JMP_ALIGN_EN
      return {a[31:2], 2'b00};
`else
      return a;
`endif
   endfunction

   function automatic logic [31:0] m_next(input logic je, input logic [31:0] jp);
      if (je) return tgt(jp);
      if (m_pend.size() > 0) return tgt(m_pend[0]);
      return m_pc + 32'd4;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive inputs, check the combinational next-PC mid-cycle,
   // then advance the model at the edge and check the registered outputs.
   task automatic step(input logic r, input logic rdy, input logic je,
                       input logic [31:0] jp);
      logic [31:0] raw;
      logic        from_jmp;
      rst          = r;
      bus.i_ready  = rdy;
      bus.i_jmp_en = je;
      bus.i_jmp_pc = jp;
      @(negedge clk);
      if (!r) chk("pc_next", bus.o_pc_next, m_next(je, jp));
      @(posedge clk);
      from_jmp = je || (m_pend.size() > 0);
      raw      = je ? jp : ((m_pend.size() > 0) ? m_pend[0] : 32'd0);
      m_mis    = 1'b0;
      if (r) begin
         m_pc    = c_reset_pc;
         m_valid = 1'b0;
         m_pend.delete();
      end else begin
         if (m_valid && rdy) begin
            m_mis = from_jmp && (raw[1:0] != 2'b00);
            m_pc  = m_next(je, jp);
            m_pend.delete();
         end else if (m_valid && je) begin
            m_pend.delete();
            m_pend.push_back(jp);
         end
         m_valid = 1'b1;
      end
      #1;
      chk("pc", bus.o_pc, m_pc);
      chk("valid", {31'd0, bus.o_valid}, {31'd0, m_valid});
`ifdef IFU_JMP_ALIGN_EN
      chk("misalign", {31'd0, bus.o_jmp_misalign}, {31'd0, m_mis});
`endif
   endtask

   initial begin
      total = 0;
      bad   = 0;
      m_pc  = 32'd0;
      m_valid = 1'b0;
      m_mis = 1'b0;
      rst   = 1'b1;
      bus.i_ready  = 1'b1;
      bus.i_jmp_en = 1'b0;
      bus.i_jmp_pc = 32'd0;
      @(posedge clk);
      #1;

      // Reset and sequential run
      step(1, 1, 0, 0);
      chk("rst_pc", bus.o_pc, 32'h8000_0000);
      chk("rst_valid", {31'd0, bus.o_valid}, 32'd0);
      step(0, 1, 0, 0);
      chk("first_pc", bus.o_pc, 32'h8000_0000);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
      chk("seq_5", bus.o_pc, 32'h8000_0014);

      // Redirect held for several cycles, then released
      for (int i = 0; i < 5; i++) step(0, 1, 1, 32'h9000_0000);
      chk("jmp_hold", bus.o_pc, 32'h9000_0000);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      chk("jmp_after", bus.o_pc, 32'h9000_0008);

      // Stall then resume exactly one step
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
      chk("stall_hold", bus.o_pc, 32'h9000_0008);
      step(0, 1, 0, 0);
      chk("stall_resume", bus.o_pc, 32'h9000_000C);

      // Jump pulse during stall, then release two cycles later
      step(0, 0, 1, 32'h9000_0100);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("pend_hold", bus.o_pc, 32'h9000_000C);
      step(0, 1, 0, 0);
      chk("pend_take", bus.o_pc, 32'h9000_0100);
      step(0, 1, 0, 0);
      chk("pend_after", bus.o_pc, 32'h9000_0104);

      // Two stalled jumps: the later one wins
      step(0, 0, 1, 32'hA000_0000);
      step(0, 0, 1, 32'hB000_0000);
      step(0, 1, 0, 0);
      chk("pend_latest", bus.o_pc, 32'hB000_0000);

      // Wrap-around
      step(0, 1, 1, 32'hFFFF_FFFC);
      step(0, 1, 0, 0);
      chk("wrap", bus.o_pc, 32'h0000_0000);

      // Reset with a pending jump; jump on release cycle is ignored
      step(0, 0, 1, 32'hC000_0000);
      step(1, 0, 0, 0);
      chk("rst_mid_valid", {31'd0, bus.o_valid}, 32'd0);
      step(0, 1, 1, 32'hD000_0000);
      chk("rst_mid_pc", bus.o_pc, 32'h8000_0000);
      step(0, 1, 0, 0);
      chk("rst_no_pend", bus.o_pc, 32'h8000_0004);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 59) == 0),
              ($urandom_range(0, 2) != 0),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
